// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command driver slice.
//   XLEN, FUNC_W       : operand/result width and function-code width
//   FUNC_ADD..FUNC_SLTU : ALU function codes; FUNC_LAST is the highest legal code
//   state_t            : command driver FSM states
//   func_legal()       : true when a function code is implemented by the ALU
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int XLEN   = 32;
   localparam int FUNC_W = 5;

   localparam logic [FUNC_W-1:0] FUNC_ADD  = 5'd0;
   localparam logic [FUNC_W-1:0] FUNC_SLL  = 5'd1;
   localparam logic [FUNC_W-1:0] FUNC_XOR  = 5'd2;
   localparam logic [FUNC_W-1:0] FUNC_SRL  = 5'd3;
   localparam logic [FUNC_W-1:0] FUNC_OR   = 5'd4;
   localparam logic [FUNC_W-1:0] FUNC_AND  = 5'd5;
   localparam logic [FUNC_W-1:0] FUNC_SUB  = 5'd6;
   localparam logic [FUNC_W-1:0] FUNC_SRA  = 5'd7;
   localparam logic [FUNC_W-1:0] FUNC_SLT  = 5'd8;
   localparam logic [FUNC_W-1:0] FUNC_SLTU = 5'd9;
   localparam logic [FUNC_W-1:0] FUNC_LAST = 5'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic logic func_legal(input logic [FUNC_W-1:0] func);
      return func <= FUNC_LAST;
   endfunction

endpackage

// File: rtl/alu_cmd_driver_if.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver_if
// Command and result handshake bundle of the ALU command driver.
//   cmd_valid/cmd_ready        : command handshake
//   cmd_a, cmd_b, cmd_func     : operands and function code
//   cmd_tag                    : request tag
//   res_valid/res_ready        : result handshake
//   res_data, res_tag          : captured result and echoed tag
//   res_err                    : illegal function code reported
//   res_mismatch               : optional checker disagreement
// Modports: master = sequencer side, slave = driver side.
// ---------------------------------------------------------------------------
interface alu_cmd_driver_if
   import alu_pkg::*;
#(
   parameter int TAG_W = 4
);

   logic              cmd_valid;
   logic              cmd_ready;
   logic [XLEN-1:0]   cmd_a;
   logic [XLEN-1:0]   cmd_b;
   logic [FUNC_W-1:0] cmd_func;
   logic [TAG_W-1:0]  cmd_tag;

   logic              res_valid;
   logic              res_ready;
   logic [XLEN-1:0]   res_data;
   logic [TAG_W-1:0]  res_tag;
   logic              res_err;
   logic              res_mismatch;

   modport master (
      output cmd_valid, cmd_a, cmd_b, cmd_func, cmd_tag, res_ready,
      input  cmd_ready, res_valid, res_data, res_tag, res_err, res_mismatch
   );

   modport slave (
      input  cmd_valid, cmd_a, cmd_b, cmd_func, cmd_tag, res_ready,
      output cmd_ready, res_valid, res_data, res_tag, res_err, res_mismatch
   );

endinterface

// File: rtl/alu_ref_model.sv
// ---------------------------------------------------------------------------
// alu_ref_model
// Purely combinational golden model of the ALU, used by the optional
// result checker of alu_cmd_driver.
//   a, b   in  XLEN   operands (shift amount is b[4:0])
//   func   in  FUNC_W function code
//   result out XLEN   expected ALU output (0 for illegal codes)
// ---------------------------------------------------------------------------
module alu_ref_model
   import alu_pkg::*;
(
   input  logic [XLEN-1:0]   a,
   input  logic [XLEN-1:0]   b,
   input  logic [FUNC_W-1:0] func,
   output logic [XLEN-1:0]   result
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (func)
         FUNC_ADD:  result = a + b;
         FUNC_SLL:  result = a << shamt;
         FUNC_XOR:  result = a ^ b;
         FUNC_SRL:  result = a >> shamt;
         FUNC_OR:   result = a | b;
         FUNC_AND:  result = a & b;
         FUNC_SUB:  result = a - b;
         FUNC_SRA:  result = XLEN'($signed(a) >>> shamt);
         FUNC_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         FUNC_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
         default:   result = '0;
      endcase
   end

endmodule

// File: rtl/alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// alu_cmd_driver
// Flow-controlled initiator for the ALU: accepts one command, drives the ALU
// inputs, waits ALU_LAT cycles, captures io_output and returns it with the
// request tag. At most one command is outstanding.
//   clk, rst (async, active low)
//   bus          : alu_cmd_driver_if.slave (command and result handshakes)
//   alu_input1/2 : to ALU io_input1/io_input2
//   alu_function : to ALU io_function
//   alu_output   : from ALU io_output
//   busy         : FSM not in IDLE
// Parameters: TAG_W (must match the interface), ALU_LAT (0..15).
// Optional feature: define ALU_CMD_DRIVER_CHECK_EN to compare alu_output
// against alu_ref_model at capture and report it on res_mismatch.
// ---------------------------------------------------------------------------
module alu_cmd_driver
   import alu_pkg::*;
#(
   parameter int TAG_W   = 4,
   parameter int ALU_LAT = 1
)(
   input  logic              clk,
   input  logic              rst,
   alu_cmd_driver_if.slave   bus,
   output logic [XLEN-1:0]   alu_input1,
   output logic [XLEN-1:0]   alu_input2,
   output logic [FUNC_W-1:0] alu_function,
   input  logic [XLEN-1:0]   alu_output,
   output logic              busy
);

   localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

   state_t            state;
   state_t            state_next;
   logic [3:0]        cnt;
   logic              illegal_q;
   logic [TAG_W-1:0]  tag_q;
   logic              accept;
   logic              capture;
   logic              cmd_legal;

   logic              res_valid_q;
   logic [XLEN-1:0]   res_data_q;
   logic [TAG_W-1:0]  res_tag_q;
   logic              res_err_q;

   // cmd_ready is a pure function of state (plus reset), so res_ready can
   // never reach it combinationally; it stays low while reset is asserted.
   assign bus.cmd_ready = (state == IDLE) && rst;
   assign busy          = (state != IDLE);
   assign accept        = (state == IDLE) && bus.cmd_valid;
   assign capture       = (state == WAIT) && (cnt == '0);
   assign cmd_legal     = func_legal(bus.cmd_func);

   assign bus.res_valid = res_valid_q;
   assign bus.res_data  = res_data_q;
   assign bus.res_tag   = res_tag_q;
   assign bus.res_err   = res_err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Illegal commands also pass through WAIT with a zero count so that their
   // error result appears exactly one cycle after acceptance.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)        state_next = WAIT;
         WAIT:    if (cnt == '0)     state_next = HOLD;
         HOLD:    if (bus.res_ready) state_next = IDLE;
         default:                    state_next = IDLE;
      endcase
   end

   // ALU inputs only change on a legal acceptance, so they stay static
   // between commands and across illegal ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_input1   <= '0;
         alu_input2   <= '0;
         alu_function <= '0;
         tag_q        <= '0;
         illegal_q    <= 1'b0;
         cnt          <= '0;
      end else begin
         if (accept) begin
            tag_q     <= bus.cmd_tag;
            illegal_q <= !cmd_legal;
            cnt       <= cmd_legal ? LAT_LOAD : 4'd0;
            if (cmd_legal) begin
               alu_input1   <= bus.cmd_a;
               alu_input2   <= bus.cmd_b;
               alu_function <= bus.cmd_func;
            end
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_tag_q   <= '0;
         res_err_q   <= 1'b0;
      end else begin
         if (capture) begin
            res_valid_q <= 1'b1;
            res_data_q  <= illegal_q ? '0 : alu_output;
            res_tag_q   <= tag_q;
            res_err_q   <= illegal_q;
         end else if ((state == HOLD) && bus.res_ready) begin
            res_valid_q <= 1'b0;
         end
      end
   end

`ifdef ALU_CMD_DRIVER_CHECK_EN
   logic [XLEN-1:0] expected;
   logic            mismatch_q;

   alu_ref_model u_ref_model (
      .a      (alu_input1),
      .b      (alu_input2),
      .func   (alu_function),
      .result (expected)
   );

   // An illegal command never drove the ALU, so there is nothing to compare.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mismatch_q <= 1'b0;
      end else if (capture) begin
         mismatch_q <= !illegal_q && (expected != alu_output);
      end
   end

   assign bus.res_mismatch = mismatch_q;
`else
   assign bus.res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_driver
// Scoreboard bench for alu_cmd_driver with a one-stage behavioural ALU.
// Stimulus pushes the expected response at acceptance; an independent monitor
// pops and compares whenever res_valid rises, and checks hold stability.
// ---------------------------------------------------------------------------
module tb_alu_cmd_driver;

   localparam int LAT = 1;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  tag;
      logic        err;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  func;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_input1;
   logic [31:0] alu_input2;
   logic [4:0]  alu_function;
   logic [31:0] alu_output;
   logic        busy;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   logic rand_ready = 1'b0;

   logic [31:0] last_in1 = '0;
   logic [31:0] last_in2 = '0;
   logic [4:0]  last_func = '0;

   alu_cmd_driver_if #(.TAG_W(4)) bus();

   alu_cmd_driver #(.TAG_W(4), .ALU_LAT(LAT)) dut (
      .clk          (clk),
      .rst          (rst),
      .bus          (bus),
      .alu_input1   (alu_input1),
      .alu_input2   (alu_input2),
      .alu_function (alu_function),
      .alu_output   (alu_output),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural ALU result straight from the operation definitions.
   function automatic logic [31:0] refAlu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] f);
      int unsigned sh;
      sh = b % 32;
      case (f)
         5'd0:    return a + b;
         5'd1:    return a << sh;
         5'd2:    return a ^ b;
         5'd3:    return a >> sh;
         5'd4:    return a | b;
         5'd5:    return a & b;
         5'd6:    return a - b;
         5'd7:    return $unsigned($signed(a) >>> sh);
         5'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd9:    return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // One register stage between ALU inputs and io_output.
   always @(posedge clk) alu_output <= refAlu(alu_input1, alu_input2, alu_function);

   always @(posedge clk) begin
      #1;
      if (rand_ready) bus.res_ready = ($urandom_range(0, 3) != 0);
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Called at a negedge; returns at the negedge following acceptance.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                input logic [4:0] f, input logic [3:0] tag);
      exp_t e;
      int   w;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      bus.cmd_func  = f;
      bus.cmd_tag   = tag;
      bus.cmd_valid = 1'b1;
      w = 0;
      while (!bus.cmd_ready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!bus.cmd_ready) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         bus.cmd_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      e.err = (f > 5'd9);
      if (!e.err) begin
         last_in1  = a;
         last_in2  = b;
         last_func = f;
      end
      e.data = e.err ? 32'd0 : refAlu(a, b, f);
      e.tag  = tag;
      e.in1  = last_in1;
      e.in2  = last_in2;
      e.func = last_func;
      e.lat  = e.err ? 1 : LAT + 1;
      e.acc  = cyc;
      exp_q.push_back(e);
   endtask

   // Monitor: handshake values as the DUT saw them at the last edge.
   logic        valid_at_edge = 1'b0;
   logic        ready_at_edge = 1'b0;
   logic [31:0] held_data;
   logic [3:0]  held_tag;
   logic        held_err;

   always @(posedge clk) begin
      valid_at_edge <= bus.res_valid;
      ready_at_edge <= bus.res_ready;
   end

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         if (bus.res_valid && !valid_at_edge) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               checkOutput("res_data", bus.res_data, e.data);
               checkOutput("res_tag", 32'(bus.res_tag), 32'(e.tag));
               checkOutput("res_err", 32'(bus.res_err), 32'(e.err));
               checkOutput("res_mismatch", 32'(bus.res_mismatch), 32'd0);
               checkOutput("alu_input1", alu_input1, e.in1);
               checkOutput("alu_input2", alu_input2, e.in2);
               checkOutput("alu_function", 32'(alu_function), 32'(e.func));
               checkOutput("latency", 32'(cyc - e.acc), 32'(e.lat));
               checkOutput("cmd_ready_hold", 32'(bus.cmd_ready), 32'd0);
            end
            held_data = bus.res_data;
            held_tag  = bus.res_tag;
            held_err  = bus.res_err;
         end else if (valid_at_edge && ready_at_edge) begin
            checkOutput("res_valid_drop", 32'(bus.res_valid), 32'd0);
         end else if (valid_at_edge && !ready_at_edge) begin
            checkOutput("hold_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("hold_data", bus.res_data, held_data);
            checkOutput("hold_tag", 32'(bus.res_tag), 32'(held_tag));
            checkOutput("hold_err", 32'(bus.res_err), 32'(held_err));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      rst           = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.cmd_func  = '0;
      bus.cmd_tag   = '0;
      bus.res_ready = 1'b0;

      #2;
      checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("rst_res_data", bus.res_data, 32'd0);
      checkOutput("rst_alu_input1", alu_input1, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);

      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      checkOutput("post_rst_busy", 32'(busy), 32'd0);

      $display("[TB] directed operations");
      bus.res_ready = 1'b1;
      applyStimulus(32'h12345678, 32'h09abcdef, 5'd0, 4'h3);
      applyStimulus(32'h12345678, 32'h9abcdef0, 5'd6, 4'h7);
      applyStimulus(32'h80000000, 32'h00000004, 5'd7, 4'h9);
      applyStimulus(32'h80000000, 32'h7fffffff, 5'd8, 4'hA);
      applyStimulus(32'h80000000, 32'h7fffffff, 5'd9, 4'hB);
      applyStimulus(32'hdeadbeef, 32'hcafef00d, 5'h1f, 4'hC);
      applyStimulus(32'h00000001, 32'h00000003, 5'd10, 4'hD);

      $display("[TB] backpressure");
      repeat (3) @(negedge clk);
      bus.res_ready = 1'b0;
      applyStimulus(32'h00000005, 32'h00000006, 5'd0, 4'h5);
      w = 0;
      while (!bus.res_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      checkOutput("bp_result_seen", 32'(bus.res_valid), 32'd1);
      bus.cmd_a     = 32'h11111111;
      bus.cmd_b     = 32'h22222222;
      bus.cmd_func  = 5'd2;
      bus.cmd_tag   = 4'hE;
      bus.cmd_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
         checkOutput("bp_busy", 32'(busy), 32'd1);
      end
      bus.cmd_valid = 1'b0;
      bus.res_ready = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("bp_no_extra", 32'(exp_q.size()), 32'd0);

      $display("[TB] reset during WAIT");
      applyStimulus(32'h0f0f0f0f, 32'h00000001, 5'd4, 4'h6);
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_alu_input1", alu_input1, 32'd0);
      checkOutput("mid_rst_alu_input2", alu_input2, 32'd0);
      checkOutput("mid_rst_alu_function", 32'(alu_function), 32'd0);
      checkOutput("mid_rst_res_valid", 32'(bus.res_valid), 32'd0);
      checkOutput("mid_rst_res_tag", 32'(bus.res_tag), 32'd0);
      checkOutput("mid_rst_res_err", 32'(bus.res_err), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      exp_q.delete();
      last_in1  = '0;
      last_in2  = '0;
      last_func = '0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      repeat (10) @(negedge clk);
      checkOutput("rel_no_result", 32'(bus.res_valid), 32'd0);

      $display("[TB] randomized commands");
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         logic [31:0] a;
         logic [31:0] b;
         logic [4:0]  f;
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 4) == 0) a = 32'h80000000;
         if ($urandom_range(0, 5) == 0) f = 5'($urandom_range(10, 31));
         else                           f = 5'($urandom_range(0, 9));
         applyStimulus(a, b, f, 4'($urandom_range(0, 15)));
      end

      rand_ready = 1'b0;
      @(posedge clk);
      #2;
      bus.res_ready = 1'b1;
      w = 0;
      while (exp_q.size() != 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      checkOutput("drain", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
